// File: rtl/quad_encoder_array.sv
// N-channel quadrature front end: per-phase sync and glitch filter, x4 decode into
// wrapping position counters, fixed-window saturating velocity and sticky error flags.
module quad_encoder_array #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 16,
  parameter int VEL_W      = 12,
  parameter int FILT_LEN   = 3,
  parameter int VEL_PERIOD = 100000
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESET,
  input  logic [N_CH-1:0]         ENC_A,
  input  logic [N_CH-1:0]         ENC_B,
  input  logic [N_CH-1:0]         dir_inv,
  input  logic [N_CH-1:0]         clr_pos,
  input  logic                    err_clr,
  output logic [N_CH*CNT_W-1:0]   pos_out,
  output logic [N_CH*VEL_W-1:0]   vel_out,
  output logic                    vel_valid,
  output logic [N_CH-1:0]         err_flag
);

  localparam int FC_W  = $clog2(FILT_LEN);
  localparam int WIN_W = $clog2(VEL_PERIOD);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FILT_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);
  localparam logic [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic [VEL_W-1:0] VEL_MIN  = {1'b1, {(VEL_W-1){1'b0}}};

  // Phase bits: [N_CH-1:0] are A, [2*N_CH-1:N_CH] are B.
  logic [2*N_CH-1:0]  w_raw;
  logic [2*N_CH-1:0]  r_sync1, r_sync2, r_filt, r_filt_d;
  logic [FC_W-1:0]    r_fcnt [2*N_CH];
  logic [2*N_CH-1:0]  w_step;
  logic [N_CH-1:0]    w_err;
  logic [2*N_CH-1:0]  r_step;
  logic [N_CH-1:0]    r_err;
  logic [N_CH*CNT_W-1:0] r_pos;
  logic [N_CH*VEL_W-1:0] r_acc, r_vel, w_acc_next;
  logic [N_CH-1:0]    r_err_flag;
  logic [WIN_W-1:0]   r_win;
  logic               r_vel_valid;
  logic               w_win_end;

  assign w_raw = {ENC_B, ENC_A};

  // Position along the forward cycle 00,10,11,01 so a legal step is a +/-1 difference.
  function automatic logic [1:0] gray_idx(input logic a, input logic b);
    return {b, a ^ b};
  endfunction

  function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] acc,
                                               input logic [1:0] step);
    logic [VEL_W:0] sum;
    sum = {acc[VEL_W-1], acc} + {{(VEL_W-1){step[1]}}, step};
    if (sum[VEL_W] != sum[VEL_W-1]) return sum[VEL_W] ? VEL_MIN : VEL_MAX;
    return sum[VEL_W-1:0];
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt   <= '0;
      r_filt_d <= '0;
      for (int j = 0; j < 2*N_CH; j++) r_fcnt[j] <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      for (int j = 0; j < 2*N_CH; j++) begin
        if (r_sync2[j] != r_filt[j]) begin
          if (r_fcnt[j] == FC_LAST) begin
            r_filt[j] <= r_sync2[j];
            r_fcnt[j] <= '0;
          end else begin
            r_fcnt[j] <= r_fcnt[j] + FC_W'(1);
          end
        end else begin
          r_fcnt[j] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_step = '0;
    w_err  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      case (gray_idx(r_filt[ch], r_filt[N_CH+ch]) - gray_idx(r_filt_d[ch], r_filt_d[N_CH+ch]))
        2'd1:    w_step[2*ch +: 2] = dir_inv[ch] ? 2'b11 : 2'b01;
        2'd3:    w_step[2*ch +: 2] = dir_inv[ch] ? 2'b01 : 2'b11;
        2'd2:    w_err[ch] = 1'b1;
        default: w_step[2*ch +: 2] = 2'b00;
      endcase
    end
  end

  assign w_win_end = (r_win == WIN_LAST);

  always_comb begin
    w_acc_next = '0;
    for (int ch = 0; ch < N_CH; ch++)
      w_acc_next[ch*VEL_W +: VEL_W] = sat_add(r_acc[ch*VEL_W +: VEL_W], r_step[2*ch +: 2]);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      r_step      <= '0;
      r_err       <= '0;
      r_pos       <= '0;
      r_acc       <= '0;
      r_vel       <= '0;
      r_err_flag  <= '0;
      r_win       <= '0;
      r_vel_valid <= 1'b0;
    end else begin
      r_step      <= w_step;
      r_err       <= w_err;
      r_win       <= w_win_end ? '0 : r_win + WIN_W'(1);
      r_vel_valid <= w_win_end;
      r_err_flag  <= r_err | (r_err_flag & ~{N_CH{err_clr}});
      for (int ch = 0; ch < N_CH; ch++) begin
        if (clr_pos[ch])
          r_pos[ch*CNT_W +: CNT_W] <= '0;
        else
          r_pos[ch*CNT_W +: CNT_W] <= r_pos[ch*CNT_W +: CNT_W]
                                      + CNT_W'($signed(r_step[2*ch +: 2]));
      end
      // Velocity keeps counting through clr_pos; the closing step joins the reported window.
      if (w_win_end) begin
        r_vel <= w_acc_next;
        r_acc <= '0;
      end else begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign pos_out   = r_pos;
  assign vel_out   = r_vel;
  assign vel_valid = r_vel_valid;
  assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array: reset, latency, wrap, glitch filter,
// illegal transitions, velocity windows with inversion, clr_pos priority and saturation.
module tb_quad_encoder_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  enc_a, enc_b, dir_inv, clr_pos;
  logic        err_clr;
  logic [31:0] pos_out;
  logic [23:0] vel_out;
  logic        vel_valid;
  logic [1:0]  err_flag;

  logic [1:0]  s_enc_a, s_enc_b, s_zero2;
  logic        s_zero1;
  logic [31:0] s_pos;
  logic [23:0] s_vel;
  logic        s_valid;
  logic [1:0]  s_err;

  int n_total = 0;
  int n_bad   = 0;
  int idx [2];

  always #5 clk = ~clk;

  quad_encoder_array #(
    .N_CH(2), .CNT_W(16), .VEL_W(12), .FILT_LEN(3), .VEL_PERIOD(1000)
  ) u_dut (
    .CLK100MHZ(clk), .CPU_RESET(rst), .ENC_A(enc_a), .ENC_B(enc_b),
    .dir_inv(dir_inv), .clr_pos(clr_pos), .err_clr(err_clr),
    .pos_out(pos_out), .vel_out(vel_out), .vel_valid(vel_valid), .err_flag(err_flag)
  );

  quad_encoder_array #(
    .N_CH(2), .CNT_W(16), .VEL_W(12), .FILT_LEN(3), .VEL_PERIOD(16000)
  ) u_sat (
    .CLK100MHZ(clk), .CPU_RESET(rst), .ENC_A(s_enc_a), .ENC_B(s_enc_b),
    .dir_inv(s_zero2), .clr_pos(s_zero2), .err_clr(s_zero1),
    .pos_out(s_pos), .vel_out(s_vel), .vel_valid(s_valid), .err_flag(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Forward cycle 00,10,11,01 ({A,B}); dir is +1 or -1.
  task automatic drive_step(input int ch, input int dir);
    idx[ch] = (idx[ch] + dir) & 3;
    enc_a[ch] = (idx[ch] == 1) || (idx[ch] == 2);
    enc_b[ch] = (idx[ch] >= 2);
  endtask

  initial begin
    int sidx;
    bit found;
    rst = 1'b1; enc_a = '0; enc_b = '0; dir_inv = '0; clr_pos = '0; err_clr = 1'b0;
    s_enc_a = '0; s_enc_b = '0; s_zero2 = '0; s_zero1 = 1'b0;
    idx[0] = 0; idx[1] = 0;

    for (int i = 0; i < 5; i++) begin
      enc_a = enc_a ^ 2'b11;
      enc_b = enc_b ^ 2'b01;
      tick(1);
    end
    chk("rst_pos", pos_out, 32'h0);
    chk("rst_vel", {8'h0, vel_out}, 32'h0);
    chk("rst_valid", {31'h0, vel_valid}, 32'h0);
    chk("rst_err", {30'h0, err_flag}, 32'h0);
    enc_a = '0; enc_b = '0;
    tick(3);
    rst = 1'b0;

    for (int k = 1; k <= 8; k++) begin
      drive_step(0, 1);
      tick(6);
      chk("lat_before", {16'h0, pos_out[15:0]}, 32'(k - 1));
      tick(1);
      chk("lat_at", {16'h0, pos_out[15:0]}, 32'(k));
      tick(13);
    end
    chk("fwd_ch1", {16'h0, pos_out[31:16]}, 32'h0);

    clr_pos = 2'b01;
    tick(1);
    clr_pos = 2'b00;
    chk("clr_pos", {16'h0, pos_out[15:0]}, 32'h0);
    drive_step(0, -1);
    tick(7);
    chk("wrap_down", {16'h0, pos_out[15:0]}, 32'h0000_FFFF);
    tick(3);
    drive_step(0, 1);
    tick(7);
    chk("wrap_up", {16'h0, pos_out[15:0]}, 32'h0);
    tick(3);

    for (int g = 0; g < 3; g++) begin
      enc_a[1] = 1'b1;
      tick(2);
      enc_a[1] = 1'b0;
      tick(10);
      chk("glitch_pos", {16'h0, pos_out[31:16]}, 32'h0);
      chk("glitch_err", {30'h0, err_flag}, 32'h0);
    end
    enc_a[1] = 1'b1;
    tick(3);
    enc_a[1] = 1'b0;
    tick(4);
    chk("pulse3_up", {16'h0, pos_out[31:16]}, 32'h1);
    tick(3);
    chk("pulse3_back", {16'h0, pos_out[31:16]}, 32'h0);
    tick(5);

    enc_a[1] = 1'b1; enc_b[1] = 1'b1; idx[1] = 2;
    tick(10);
    chk("illegal_pos", {16'h0, pos_out[31:16]}, 32'h0);
    chk("illegal_err", {30'h0, err_flag}, 32'h2);
    tick(20);
    chk("err_sticky", {30'h0, err_flag}, 32'h2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", {30'h0, err_flag}, 32'h0);

    enc_a[1] = 1'b0; enc_b[1] = 1'b0; idx[1] = 0;
    tick(6);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_set_wins", {30'h0, err_flag}, 32'h2);
    tick(3);
    chk("err_pos_ch1", {16'h0, pos_out[31:16]}, 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr2", {30'h0, err_flag}, 32'h0);

    dir_inv = 2'b01;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive_step(0, 1);
      tick(8);
    end
    tick(599);
    chk("valid_999", {31'h0, vel_valid}, 32'h0);
    tick(1);
    chk("valid_1000", {31'h0, vel_valid}, 32'h1);
    chk("vel_neg50", {20'h0, vel_out[11:0]}, 32'h0000_0FCE);
    chk("vel_ch1", {20'h0, vel_out[23:12]}, 32'h0);
    chk("pos_inv", {16'h0, pos_out[15:0]}, 32'h0000_FFCE);
    tick(1);
    chk("valid_drop", {31'h0, vel_valid}, 32'h0);
    dir_inv = 2'b00;
    tick(998);
    chk("valid_1999", {31'h0, vel_valid}, 32'h0);
    tick(1);
    chk("valid_2000", {31'h0, vel_valid}, 32'h1);
    chk("vel_idle", {20'h0, vel_out[11:0]}, 32'h0);

    drive_step(0, 1);
    tick(6);
    clr_pos = 2'b01;
    tick(1);
    clr_pos = 2'b00;
    chk("clr_vs_step", {16'h0, pos_out[15:0]}, 32'h0);
    tick(1);
    chk("clr_step_gone", {16'h0, pos_out[15:0]}, 32'h0);
    tick(991);
    chk("valid_2999", {31'h0, vel_valid}, 32'h0);
    tick(1);
    chk("valid_3000", {31'h0, vel_valid}, 32'h1);
    chk("vel_keeps_step", {20'h0, vel_out[11:0]}, 32'h1);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    sidx = 0;
    for (int i = 0; i < 3000; i++) begin
      sidx = (sidx + 1) & 3;
      s_enc_a[0] = (sidx == 1) || (sidx == 2);
      s_enc_b[0] = (sidx >= 2);
      tick(4);
    end
    found = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick(1);
      if (s_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("sat_seen", {31'h0, found}, 32'h1);
    chk("vel_sat", {20'h0, s_vel[11:0]}, 32'h0000_07FF);
    chk("sat_ch1", {20'h0, s_vel[23:12]}, 32'h0);
    chk("sat_pos", {16'h0, s_pos[15:0]}, 32'd3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_array.md
Name: quad_encoder_array

Overview:
Parametrised N-channel quadrature encoder front end for the motor-control top. It succeeds the fixed 2-channel ENC_A/ENC_B handling and adds several functions:
- per-channel input synchronisation and glitch filtering
- x4 decoding into wrapping position counters
- fixed-window signed velocity measurement
- sticky illegal-transition flags

The PID loop and UART register map read its outputs.

Parameters:
N_CH, 2, number of encoder channels (1..8)
CNT_W, 16, position counter width per channel
VEL_W, 12, signed velocity width per channel
FILT_LEN, 3, consecutive stable samples required to accept an input change (2..15)
VEL_PERIOD, 100000, velocity window in clock cycles (1 ms at 100 MHz); must be >= 2

Ports:
CLK100MHZ  in  1  system clock, all logic on rising edge
CPU_RESET  in  1  synchronous active-high reset
ENC_A  in  N_CH  encoder A phases, asynchronous
ENC_B  in  N_CH  encoder B phases, asynchronous
dir_inv  in  N_CH  per channel, 1 = invert count direction
clr_pos  in  N_CH  per channel, 1 = clear position next edge
err_clr  in  1  clears all err_flag bits
pos_out  out  N_CH*CNT_W  unsigned position, channel i at [i*CNT_W +: CNT_W]
vel_out  out  N_CH*VEL_W  signed counts per window, channel i at [i*VEL_W +: VEL_W]
vel_valid  out  1  one-cycle pulse when vel_out updates
err_flag  out  N_CH  sticky illegal-transition flag

Behaviour:
- Reset: while CPU_RESET is high at an edge, the following are all zero: pos_out, vel_out, vel_valid, err_flag, filter state, velocity accumulators, window counter. Synchroniser flops are also loaded with 0.
- Synchronisation: 2-flop synchroniser per phase bit.
- Glitch filter (per bit): the filtered value changes only after the synchronised value has differed from it for FILT_LEN consecutive cycles. Any return to the filtered value restarts the count.
- Latency: a clean ENC edge reaches pos_out exactly 2 + FILT_LEN + 1 cycles after the first edge that samples it (6 cycles at default).
- Decode: {A,B} filtered state, previous vs current.
  - Forward sequence 00->10->11->01->00: +1.
  - Reverse sequence: -1.
  - No change: 0.
  - Both bits changed (00<->11, 10<->01): 0 and err_flag[i] set.
  - dir_inv[i] negates the step.
- Position: pos += step, modulo 2^CNT_W. 0xFFFF + 1 -> 0x0000; 0x0000 - 1 -> 0xFFFF.
- clr_pos[i] high: pos_out[i] = 0 on that edge. A coincident step is discarded (clear wins).
- Velocity:
  - Window counter counts 0..VEL_PERIOD-1 and wraps.
  - Each channel has a signed VEL_W accumulator of steps, saturating at +2^(VEL_W-1)-1 / -2^(VEL_W-1).
  - On the edge where the counter equals VEL_PERIOD-1:
    - vel_out[i] is loaded with accumulator + this cycle's step (saturated).
    - The accumulator is reset to 0.
    - vel_valid is 1 for that single cycle, otherwise 0.
  - All channels update together.
- clr_pos does not affect the velocity accumulators.
- err_flag: sticky. err_clr clears all bits; an illegal transition on the same edge as err_clr sets its bit (set wins).
- Reset mid-window: the counter restarts at 0, and the first vel_valid comes VEL_PERIOD cycles after reset deasserts.
- Multiple channels are fully independent; no arbitration.

Test Plan:
- Reset → outputs zero:
  - Stimulus: hold CPU_RESET 5 cycles with ENC toggling.
  - Required: pos_out, vel_out, err_flag = 0; vel_valid low.
- Forward count, wrap and latency (ch0, VEL_PERIOD=1000):
  - Stimulus: 8 forward quadrature steps, 20 cycles apart.
  - Required: pos ch0 = 8, ch1 = 0.
  - Required: each increment lands exactly 6 cycles after the input edge.
  - Then preload via clr_pos and count -1: pos = 0xFFFF.
- Glitch reject:
  - Stimulus: 2-cycle pulses on ENC_A[1].
  - Required: no position change; err_flag stays 0.
  - Stimulus: a 3-cycle (stable) pulse.
  - Required: exactly one count.
- Illegal transition:
  - Stimulus: ENC_A and ENC_B of ch1 switch simultaneously 00->11.
  - Required: pos ch1 unchanged; err_flag[1] = 1 and held.
  - Stimulus: err_clr pulse.
  - Required: err_flag clears.
- Velocity with dir_inv (VEL_PERIOD=1000):
  - Stimulus: ch0 forward 50 steps within a window, dir_inv[0] = 1.
  - Required: on the vel_valid pulse (cycle 1000 after reset), vel ch0 = -50 (0xFCE), and one pulse per 1000 cycles.
  - Stimulus: 3000 steps in one window.
  - Required: vel saturates at 2047.
- clr_pos vs step:
  - Stimulus: assert clr_pos[0] on the same edge that a step lands.
  - Required: pos ch0 = 0 on the next edge.
  - Required: vel ch0 for that window still includes the step.
